// File: rtl/mipi_deserializer.sv
// ==== mipi_deserializer : D-PHY HS lane SoT hunt, lock, LSB-first word assembly, byte clock ====
// Rev 1.0
`default_nettype none

module mipi_deserializer #(
   parameter int         WIDTH        = 8,
   parameter logic [7:0] SYNC_PATTERN = 8'hB8,
   parameter int         MAX_HUNT     = 32
) (
   input  logic             RxDDRClkHS,
   input  logic             RESET,
   input  logic             DRXHSP,
   input  logic             HS_DESER_EN,
   input  logic             ENP,
   output logic [WIDTH-1:0] HSRX_DATA,
   output logic             HS_BYTE_CLKD,
   output logic             SYNC,
   output logic             ERRSYNC,
   output logic             NOSYNC
);
   localparam int c_BW = $clog2(WIDTH);
   localparam int c_HW = $clog2(MAX_HUNT + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HUNT   = 2'd1,
      ST_SYNCED = 2'd2,
      ST_FAIL   = 2'd3
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [7:0]       r_win, w_win_nxt, w_win_shift, w_diff;
   logic             w_exact, w_onebit;
   logic [c_HW-1:0]  r_hcnt, w_hcnt_nxt;
   logic             r_hact, w_hact_nxt;
   logic [c_BW-1:0]  r_bcnt, w_bcnt_nxt;
   logic [WIDTH-1:0] r_sr, w_sr_nxt, r_data, w_data_nxt;
   logic             r_sync, w_sync_nxt, r_err, w_err_nxt, r_nos, w_nos_nxt;
   logic             r_bclk, w_bclk_nxt;

   assign w_win_shift = {DRXHSP, r_win[7:1]};
   assign w_diff      = w_win_shift ^ SYNC_PATTERN;
   assign w_exact     = (w_diff == 8'd0);
   // Non-zero power of two <=> exactly one differing bit
   assign w_onebit    = (w_diff != 8'd0) && ((w_diff & (w_diff - 8'd1)) == 8'd0);

   always_comb begin
      w_state_nxt = r_state;
      w_win_nxt   = w_win_shift;
      w_hcnt_nxt  = r_hcnt;
      w_hact_nxt  = r_hact;
      w_bcnt_nxt  = r_bcnt + c_BW'(1);
      w_sr_nxt    = r_sr;
      w_data_nxt  = r_data;
      w_sync_nxt  = r_sync;
      w_err_nxt   = r_err;
      w_nos_nxt   = r_nos;

      if (!HS_DESER_EN) begin
         w_state_nxt = ST_IDLE;
         w_win_nxt   = 8'd0;
         w_hcnt_nxt  = '0;
         w_hact_nxt  = 1'b0;
         w_bcnt_nxt  = '0;
         w_sync_nxt  = 1'b0;
         w_err_nxt   = 1'b0;
         w_nos_nxt   = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt = ST_HUNT;
               w_win_nxt   = 8'd0;
               w_bcnt_nxt  = '0;
            end
            ST_HUNT: begin
               if (r_hact) begin
                  w_hcnt_nxt = r_hcnt + c_HW'(1);
               end else if (DRXHSP) begin
                  w_hact_nxt = 1'b1;
                  w_hcnt_nxt = c_HW'(1);
               end
               if (w_exact) begin
                  w_sync_nxt  = 1'b1;
                  w_state_nxt = ST_SYNCED;
                  w_bcnt_nxt  = '0;
               end else if (w_onebit) begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = ST_SYNCED;
                  w_bcnt_nxt  = '0;
               end else if (w_hcnt_nxt == c_HW'(MAX_HUNT)) begin
                  w_nos_nxt   = 1'b1;
                  w_state_nxt = ST_FAIL;
               end
            end
            ST_SYNCED: begin
               w_sr_nxt = {DRXHSP, r_sr[WIDTH-1:1]};
               if (r_bcnt == c_BW'(WIDTH - 1)) begin
                  w_data_nxt = w_sr_nxt;
               end
            end
            default: begin
            end
         endcase
      end

      // WIDTH is a power of two, so the counter MSB clear means the first half-period
      w_bclk_nxt = ENP && (w_state_nxt != ST_IDLE) && !w_bcnt_nxt[c_BW-1];
   end

   always_ff @(posedge RxDDRClkHS or posedge RESET) begin
      if (RESET) begin
         r_state <= ST_IDLE;
         r_win   <= 8'd0;
         r_hcnt  <= '0;
         r_hact  <= 1'b0;
         r_bcnt  <= '0;
         r_sr    <= '0;
         r_data  <= '0;
         r_sync  <= 1'b0;
         r_err   <= 1'b0;
         r_nos   <= 1'b0;
         r_bclk  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_win   <= w_win_nxt;
         r_hcnt  <= w_hcnt_nxt;
         r_hact  <= w_hact_nxt;
         r_bcnt  <= w_bcnt_nxt;
         r_sr    <= w_sr_nxt;
         r_data  <= w_data_nxt;
         r_sync  <= w_sync_nxt;
         r_err   <= w_err_nxt;
         r_nos   <= w_nos_nxt;
         r_bclk  <= w_bclk_nxt;
      end
   end

   assign HSRX_DATA    = r_data;
   assign HS_BYTE_CLKD = r_bclk;
   assign SYNC         = r_sync;
   assign ERRSYNC      = r_err;
   assign NOSYNC       = r_nos;

endmodule

`default_nettype wire

// File: tb/tb_mipi_deserializer.sv
// ==== tb_mipi_deserializer : randomized stimulus against a bit-list reference model ====
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_mipi_deserializer;
   localparam int         W    = 8;
   localparam logic [7:0] PAT  = 8'hB8;
   localparam int         MAXH = 32;

   localparam int M_IDLE   = 0;
   localparam int M_HUNT   = 1;
   localparam int M_LOCKED = 2;
   localparam int M_NOLOCK = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         d   = 1'b0;
   logic         en  = 1'b0;
   logic         enp = 1'b0;
   logic [W-1:0] data;
   logic         bclk, sync, errsync, nosync;

   mipi_deserializer #(.WIDTH(W), .SYNC_PATTERN(PAT), .MAX_HUNT(MAXH)) dut (
      .RxDDRClkHS   (clk),
      .RESET        (rst),
      .DRXHSP       (d),
      .HS_DESER_EN  (en),
      .ENP          (enp),
      .HSRX_DATA    (data),
      .HS_BYTE_CLKD (bclk),
      .SYNC         (sync),
      .ERRSYNC      (errsync),
      .NOSYNC       (nosync)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: bits seen while hunting and payload bits kept as plain lists
   int           m_st, m_phase, m_hcnt;
   bit           m_hact;
   bit           hist[$];
   bit           pay[$];
   logic [W-1:0] m_data;
   logic         m_sync, m_err, m_nos, m_bclk;

   function automatic logic [7:0] model_window();
      logic [7:0] w = 8'd0;
      int n = hist.size();
      for (int j = 0; j < 8; j++)
         if (n - 8 + j >= 0) w[j] = hist[n-8+j];
      return w;
   endfunction

   task automatic model_reset();
      m_st = M_IDLE; m_phase = 0; m_hcnt = 0; m_hact = 0;
      hist.delete(); pay.delete();
      m_data = '0; m_sync = 0; m_err = 0; m_nos = 0; m_bclk = 0;
   endtask

   task automatic model_edge(input bit e, input bit p, input bit b);
      logic [7:0] w;
      if (!e) begin
         m_st = M_IDLE; m_phase = 0; m_hcnt = 0; m_hact = 0;
         hist.delete(); pay.delete();
         m_sync = 0; m_err = 0; m_nos = 0; m_bclk = 0;
      end else if (m_st == M_IDLE) begin
         m_st = M_HUNT; m_phase = 0; m_bclk = p;
      end else begin
         m_phase = (m_phase + 1) % W;
         if (m_st == M_HUNT) begin
            hist.push_back(b);
            if (m_hact) m_hcnt++;
            else if (b) begin m_hact = 1; m_hcnt = 1; end
            w = model_window();
            if (w == PAT) begin
               m_sync = 1; m_st = M_LOCKED; m_phase = 0; pay.delete();
            end else if ($countones(w ^ PAT) == 1) begin
               m_err = 1; m_st = M_LOCKED; m_phase = 0; pay.delete();
            end else if (m_hcnt == MAXH) begin
               m_nos = 1; m_st = M_NOLOCK;
            end
         end else if (m_st == M_LOCKED) begin
            pay.push_back(b);
            if (pay.size() == W) begin
               for (int i = 0; i < W; i++) m_data[i] = pay[i];
               pay.delete();
            end
         end
         m_bclk = p && (m_phase < W / 2);
      end
   endtask

   task automatic step(input bit e, input bit p, input bit b);
      en = e; enp = p; d = b;
      @(posedge clk);
      model_edge(e, p, b);
      #1;
      chk_val("data",    data,    m_data);
      chk_val("bclk",    bclk,    m_bclk);
      chk_val("sync",    sync,    m_sync);
      chk_val("errsync", errsync, m_err);
      chk_val("nosync",  nosync,  m_nos);
   endtask

   task automatic send8(input logic [7:0] v, input bit p);
      for (int i = 0; i < 8; i++) step(1'b1, p, v[i]);
   endtask

   task automatic lock_exact(input bit p);
      step(1'b0, p, 1'b0);
      step(1'b1, p, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, p, 1'b0);
      send8(PAT, p);
   endtask

   initial begin
      int         hi, rises, kind, nwords;
      logic       prev;
      logic [7:0] v, r0, r1, ldr;
      bit         p;

      #12;
      chk_val("rst_data",    data,    32'h0);
      chk_val("rst_bclk",    bclk,    32'h0);
      chk_val("rst_sync",    sync,    32'h0);
      chk_val("rst_errsync", errsync, 32'h0);
      chk_val("rst_nosync",  nosync,  32'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;

      // Exact leader, then 0x5A
      step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);
      send8(PAT, 1'b1);
      chk_val("t2_sync", sync, 32'h1);
      send8(8'h5A, 1'b1);
      chk_val("t2_data", data, 32'h5A);
      chk_val("t2_bclk", bclk, 32'h1);

      // Asynchronous reset between edges
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk_val("arst_data", data, 32'h0);
      chk_val("arst_bclk", bclk, 32'h0);
      chk_val("arst_sync", sync, 32'h0);
      model_reset();
      #1 rst = 1'b0;

      // One-bit-error leader (0xA8), then 0xC3
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
      send8(8'hA8, 1'b1);
      chk_val("t3_errsync", errsync, 32'h1);
      chk_val("t3_sync",    sync,    32'h0);
      send8(8'hC3, 1'b1);
      chk_val("t3_data", data, 32'hC3);

      // Hunt timeout: period-3 noise (plain 1/0 alternation lands within one bit of the leader early on)
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      for (int i = 1; i <= 41; i++) begin
         step(1'b1, 1'b1, ((i - 1) % 3) == 0);
         chk_val("t4_nosync", nosync, (i >= MAXH) ? 32'h1 : 32'h0);
      end
      chk_val("t4_data", data, 32'hC3);

      // ENP low while words keep flowing
      lock_exact(1'b1);
      r0 = 8'($urandom); r1 = 8'($urandom);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, r0[i]);
         chk_val("t5_bclk_off", bclk, 32'h0);
      end
      chk_val("t5_data0", data, {24'h0, r0});
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, r1[i]);
      send8(8'h01, 1'b1);
      chk_val("t5_data01", data, 32'h01);
      send8(8'hFF, 1'b1);
      chk_val("t5_dataFF", data, 32'hFF);
      hi = 0; rises = 0; prev = bclk;
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b1, 1'($urandom));
         if (bclk) hi++;
         if (bclk && !prev) rises++;
         prev = bclk;
      end
      chk_val("t5_duty",  hi,    32'd8);
      chk_val("t5_rises", rises, 32'd2);

      // Abort a partial word, then relock
      lock_exact(1'b1);
      send8(8'h3C, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      chk_val("t6_sync_clr", sync, 32'h0);
      chk_val("t6_data_hold", data, 32'h3C);
      step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0);
      send8(PAT, 1'b1);
      chk_val("t6_resync", sync, 32'h1);
      send8(8'h96, 1'b1);
      chk_val("t6_data", data, 32'h96);

      // Randomized scenarios
      for (int it = 0; it < 80; it++) begin
         p = 1'($urandom);
         step(1'b0, p, 1'($urandom));
         step(1'b1, p, 1'b0);
         for (int i = 0; i < int'($urandom_range(0, 5)); i++) step(1'b1, 1'($urandom), 1'b0);
         kind = int'($urandom_range(0, 3));
         if (kind == 3) begin
            for (int i = 0; i < 45; i++) step(1'b1, 1'($urandom), 1'($urandom));
         end else begin
            ldr = PAT;
            if (kind == 2) ldr = ldr ^ (8'h01 << $urandom_range(0, 7));
            send8(ldr, 1'($urandom));
         end
         nwords = int'($urandom_range(1, 3));
         for (int k = 0; k < nwords * 8; k++) begin
            if ($urandom_range(0, 99) == 0) begin
               step(1'b0, 1'($urandom), 1'($urandom));
               break;
            end
            step(1'b1, 1'($urandom), 1'($urandom));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
